// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the GPR write port, merging in-order MEM/WB results
// with buffered long-latency results, plus a per-GPR pending scoreboard for decode.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LL_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mw_valid,
    input  logic                 mw_we,
    input  logic [ADDR_W-1:0]    mw_addr,
    input  logic [DATA_W-1:0]    mw_data,
    output logic                 mw_ready,
    input  logic                 ll_valid,
    input  logic [ADDR_W-1:0]    ll_addr,
    input  logic [DATA_W-1:0]    ll_data,
    output logic                 ll_ready,
    input  logic                 ll_issue,
    input  logic [ADDR_W-1:0]    ll_issue_addr,
    output logic [2**ADDR_W-1:0] sb_busy,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]    rf_wr_data
);
    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam int CNT_W = $clog2(LL_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LL_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LL_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {SRC_NONE, SRC_MW, SRC_LL} src_e;

    logic [ADDR_W-1:0] fifo_addr [LL_DEPTH];
    logic [DATA_W-1:0] fifo_data [LL_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt, starve_next;
    logic [NREG-1:0]   busy_q, busy_next, set_mask, clr_mask;

    logic              fifo_empty, fifo_full, mw_write, force_drain;
    logic              pop, push, wr_en;
    src_e              src;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_FULL);
    assign head_addr   = fifo_addr[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];
    assign mw_write    = mw_valid & mw_we & (mw_addr != '0);
    assign force_drain = ~fifo_empty & (starve_cnt == STV_MAX);
    assign push        = ll_valid & ~fifo_full;
    assign ll_ready    = ~fifo_full;
    assign sb_busy     = busy_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src      = SRC_NONE;
        pop      = 1'b0;
        mw_ready = 1'b1;
        if (force_drain) begin
            mw_ready = 1'b0;
            pop      = 1'b1;
            src      = SRC_LL;
        end else if (mw_write) begin
            src = SRC_MW;
        end else if (!fifo_empty) begin
            pop = 1'b1;
            src = SRC_LL;
        end
    end

    // An LL entry targeting r0 still drains, it just produces no write.
    assign wr_en = (src == SRC_MW) || ((src == SRC_LL) && (head_addr != '0));

    always_comb begin
        starve_next = starve_cnt;
        if (pop || fifo_empty)
            starve_next = '0;
        else if (mw_write && (starve_cnt != STV_MAX))
            starve_next = starve_cnt + 1'b1;
    end

    // Clear is applied before set so an issue on the same edge as a drain keeps the bit.
    always_comb begin
        set_mask  = (ll_issue && (ll_issue_addr != '0)) ? (NREG'(1) << ll_issue_addr) : '0;
        clr_mask  = pop ? (NREG'(1) << head_addr) : '0;
        busy_next = (busy_q & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy_q     <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            starve_cnt <= starve_next;
            busy_q     <= busy_next;
            rf_we      <= wr_en;
            if (wr_en) begin
                rf_addr    <= (src == SRC_MW) ? mw_addr : head_addr;
                rf_wr_data <= (src == SRC_MW) ? mw_data : head_data;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ll_addr;
            fifo_data[wr_ptr] <= ll_data;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a queue-based model predicts each write-port
// cycle; a monitor process compares the registered outputs after every clock edge.
module tb_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int LL_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
    localparam int NREG       = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mw_valid = 1'b0, mw_we = 1'b0;
    logic [ADDR_W-1:0] mw_addr = '0;
    logic [DATA_W-1:0] mw_data = '0;
    logic              mw_ready;
    logic              ll_valid = 1'b0;
    logic [ADDR_W-1:0] ll_addr = '0;
    logic [DATA_W-1:0] ll_data = '0;
    logic              ll_ready;
    logic              ll_issue = 1'b0;
    logic [ADDR_W-1:0] ll_issue_addr = '0;
    logic [NREG-1:0]   sb_busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wr_data;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LL_DEPTH(LL_DEPTH),
                 .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .mw_valid(mw_valid), .mw_we(mw_we), .mw_addr(mw_addr), .mw_data(mw_data),
        .mw_ready(mw_ready),
        .ll_valid(ll_valid), .ll_addr(ll_addr), .ll_data(ll_data), .ll_ready(ll_ready),
        .ll_issue(ll_issue), .ll_issue_addr(ll_issue_addr),
        .sb_busy(sb_busy),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } ll_t;
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [NREG-1:0]   busy;
    } exp_t;

    ll_t               m_q[$];
    exp_t              exp_q[$];
    int                m_starve = 0;
    logic [NREG-1:0]   m_busy   = '0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_data   = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational readies against the model,
    // then advance the model and queue the expected post-edge outputs.
    task automatic step(input logic mv, input logic mwe, input logic [ADDR_W-1:0] ma,
                        input logic [DATA_W-1:0] md, input logic lv,
                        input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                        input logic iv, input logic [ADDR_W-1:0] ia, output logic acc);
        bit   empty, full, mw_wr, force_d, do_pop;
        ll_t  h;
        exp_t e;
        @(negedge clk);
        mw_valid = mv; mw_we = mwe; mw_addr = ma; mw_data = md;
        ll_valid = lv; ll_addr = la; ll_data = ld;
        ll_issue = iv; ll_issue_addr = ia;
        #1;
        empty   = (m_q.size() == 0);
        full    = (m_q.size() == LL_DEPTH);
        mw_wr   = mv && mwe && (ma != 0);
        force_d = !empty && (m_starve == STARVE_MAX);
        check("ll_ready", ll_ready, !full);
        check("mw_ready", mw_ready, !force_d);
        do_pop = !empty && (force_d || !mw_wr);
        e.we = 1'b0;
        if (do_pop) begin
            h = m_q.pop_front();
            if (h.addr != 0) begin
                e.we = 1'b1; m_addr = h.addr; m_data = h.data;
            end
            m_busy[h.addr] = 1'b0;
        end else if (mw_wr) begin
            e.we = 1'b1; m_addr = ma; m_data = md;
        end
        if (do_pop || empty)
            m_starve = 0;
        else if (m_starve < STARVE_MAX)
            m_starve = m_starve + 1;
        acc = lv && !full;
        if (acc) begin
            h.addr = la; h.data = ld;
            m_q.push_back(h);
        end
        if (iv && ia != 0)
            m_busy[ia] = 1'b1;
        m_busy[0] = 1'b0;
        e.addr = m_addr; e.data = m_data; e.busy = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mw_valid = 0; mw_we = 0; ll_valid = 0; ll_issue = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_sb_busy", sb_busy, '0);
        check("rst_ll_ready", ll_ready, 1'b1);
        check("rst_mw_ready", mw_ready, 1'b1);
        check("rst_rf_addr", rf_addr, '0);
        check("rst_rf_data", rf_wr_data, '0);
        m_q.delete(); m_starve = 0; m_busy = '0; m_addr = '0; m_data = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every edge that has a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", rf_we, e.we);
                check("rf_addr", rf_addr, e.addr);
                check("rf_wr_data", rf_wr_data, e.data);
                check("sb_busy", sb_busy, e.busy);
            end
        end
    end

    // Decode must never issue to a register that is already pending.
    always @(posedge clk)
        if (rst_n && ll_issue && ll_issue_addr != 0)
            assert (!sb_busy[ll_issue_addr])
            else $error("issue to busy register %0d", ll_issue_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic mv, mwe, lv, iv;
        logic [ADDR_W-1:0] ma, la, ia;
        int tries;

        do_reset();

        // MEM/WB-only write
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
        idle(2);

        // LL-only: issue, later result, pending bit held until written
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, acc);
        idle(2);
        step(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, acc);
        idle(3);

        // Starvation: one buffered entry under continuous pipeline writes
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, acc);
        step(1, 1, 3, 32'hA000_0000, 1, 9, 32'h9999, 0, 0, acc);
        for (int i = 1; i < 8; i++)
            step(1, 1, 3, 32'hA000_0000 + i, 0, 0, 0, 0, 0, acc);
        idle(2);

        // Full and pointer wrap: three results held until accepted, pipeline always writing
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, 0, 0, 0, 0, 1, ADDR_W'(10 + k), acc);
        for (int k = 0; k < 3; k++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                step(1, 1, 4, 32'hB000_0000 + tries, 1, ADDR_W'(10 + k),
                     32'hC000_0000 + k, 0, 0, acc);
                tries++;
            end
            check("ll_accept_bound", acc, 1'b1);
        end
        for (int i = 0; i < 12; i++)
            step(1, 1, 4, 32'hD000_0000 + i, 0, 0, 0, 0, 0, acc);
        idle(2);

        // Address 0 results: accepted and drained without writes
        step(1, 1, 0, 32'h1111_1111, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 1, 0, 32'h2222_2222, 0, 0, acc);
        idle(3);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 800)
                do_reset();
            mv  = ($urandom_range(0, 9) < 7);
            mwe = ($urandom_range(0, 9) < 8);
            ma  = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(0, NREG - 1));
            lv  = ($urandom_range(0, 9) < 3);
            la  = ADDR_W'($urandom_range(0, NREG - 1));
            iv  = ($urandom_range(0, 9) < 2);
            ia  = ADDR_W'($urandom_range(1, NREG - 1));
            if (m_busy[ia])
                iv = 1'b0;
            step(mv, mwe, ma, $urandom(), lv, la, $urandom(), iv, ia, acc);
        end
        idle(8);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
